// File: rtl/mem_request_unit.sv
// rtl/mem_request_unit.sv - memory request sequencer for the single-cycle MIPS datapath (optional counters: REQ_PERF_CNT_EN)
module mem_request_unit #(
  parameter int CNT_W    = 32,
  parameter int WAIT_MAX = 255
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             dREN_in,
  input  logic             dWEN_in,
  input  logic             halt_in,
  input  logic             ihit,
  input  logic             dhit,
  output logic             imemREN,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic             pc_en,
  output logic             halted,
  output logic             req_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2,
    HALT  = 2'd3
  } state_t;

  // Wait counter only needs to reach WAIT_MAX, where it saturates.
  localparam int WW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [WW-1:0] WAIT_LIM = WW'(WAIT_MAX);

  state_t        state, next_state;
  logic          rd_q, wr_q;
  logic          err_q;
  logic [WW-1:0] wait_cnt;
  logic          pc_en_c;
  logic          accept_mem;
  logic          waiting;
  logic          wd_trip;
  logic          illegal;

  // Next-state decode; pc_en is the only output that looks at the hit inputs directly.
  always_comb begin
    next_state = state;
    pc_en_c    = 1'b0;
    accept_mem = 1'b0;
    waiting    = 1'b0;
    case (state)
      IDLE:  next_state = FETCH;
      FETCH: begin
        if (!ihit) begin
          waiting = 1'b1;
        end else if (halt_in) begin
          next_state = HALT;
        end else if (dREN_in || dWEN_in) begin
          next_state = DATA;
          accept_mem = 1'b1;
        end else begin
          pc_en_c = 1'b1;
        end
      end
      DATA: begin
        if (!dhit) begin
          waiting = 1'b1;
        end else begin
          pc_en_c    = 1'b1;
          next_state = FETCH;
        end
      end
      HALT:    next_state = HALT;
      default: next_state = IDLE;
    endcase
  end

  // Watchdog trips on the cycle the wait counter would reach (or already sits at) the limit.
  assign wd_trip = (WAIT_MAX != 0) && waiting && (wait_cnt >= (WAIT_LIM - 1'b1));
  assign illegal = accept_mem && dREN_in && dWEN_in;

  // State register.
  always_ff @(posedge CLK) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  // Latched data intent; a simultaneous read+write request resolves to a write.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
    end else if (accept_mem) begin
      rd_q <= dREN_in & ~dWEN_in;
      wr_q <= dWEN_in;
    end else if (state == DATA && dhit) begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
    end
  end

  // Saturating wait counter, restarted on any state change or retirement.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wait_cnt <= '0;
    end else if (next_state != state || pc_en_c) begin
      wait_cnt <= '0;
    end else if (waiting && wait_cnt != WAIT_LIM) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Sticky error flag: illegal intent or watchdog expiry.
  always_ff @(posedge CLK) begin
    if (!nRST)                  err_q <= 1'b0;
    else if (illegal || wd_trip) err_q <= 1'b1;
  end

  assign imemREN = (state == FETCH);
  assign dmemREN = (state == DATA) && rd_q;
  assign dmemWEN = (state == DATA) && wr_q;
  assign halted  = (state == HALT);
  assign req_err = err_q;
  assign pc_en   = pc_en_c;

`ifdef REQ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, instr_q;

  // Saturating performance counters for hit stalls and retirements.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stall_q <= '0;
      instr_q <= '0;
    end else begin
      if (waiting && !(&stall_q)) stall_q <= stall_q + 1'b1;
      if (pc_en_c && !(&instr_q)) instr_q <= instr_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
  assign instr_cnt = instr_q;
`else
  assign stall_cnt = '0;
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_request_unit.sv
// tb/tb_mem_request_unit.sv - table-driven scoreboard bench for mem_request_unit
module tb_mem_request_unit;

  localparam int CNT_W = 32;
  localparam int WAIT_MAX = 4;
`ifdef REQ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Expected output bits: {imemREN, dmemREN, dmemWEN, pc_en, halted, req_err}
  localparam logic [5:0] O      = 6'b000000;
  localparam logic [5:0] IM     = 6'b100000;
  localparam logic [5:0] IMPC   = 6'b100100;
  localparam logic [5:0] DR     = 6'b010000;
  localparam logic [5:0] DRPC   = 6'b010100;
  localparam logic [5:0] DW     = 6'b001000;
  localparam logic [5:0] DWPC   = 6'b001100;
  localparam logic [5:0] HL     = 6'b000010;
  localparam logic [5:0] IMER   = 6'b100001;
  localparam logic [5:0] IMPCER = 6'b100101;
  localparam logic [5:0] DWER   = 6'b001001;
  localparam logic [5:0] DWPCER = 6'b001101;

  logic CLK, nRST, dREN_in, dWEN_in, halt_in, ihit, dhit;
  logic imemREN, dmemREN, dmemWEN, pc_en, halted, req_err;
  logic [CNT_W-1:0] stall_cnt, instr_cnt;

  mem_request_unit #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
    .CLK(CLK), .nRST(nRST), .dREN_in(dREN_in), .dWEN_in(dWEN_in), .halt_in(halt_in),
    .ihit(ihit), .dhit(dhit), .imemREN(imemREN), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .pc_en(pc_en), .halted(halted), .req_err(req_err), .stall_cnt(stall_cnt), .instr_cnt(instr_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string      name;
    logic       nrst, dren, dwen, halt, ih, dh;
    logic [5:0] exp;
    logic       chk_cnt;
    int         stall, instr;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int checks = 0;
  int failures = 0;

  function automatic void add(string n, logic nrst, logic dren, logic dwen, logic halt,
                              logic ih, logic dh, logic [5:0] e, logic c, int s, int i);
    vec_t v;
    v.name = n; v.nrst = nrst; v.dren = dren; v.dwen = dwen; v.halt = halt;
    v.ih = ih; v.dh = dh; v.exp = e; v.chk_cnt = c; v.stall = s; v.instr = i;
    tbl.push_back(v);
  endfunction

  initial begin
    vec_t v, e;
    logic [5:0] act;
    logic [CNT_W-1:0] exp_s, exp_i;

    // Reset release and back-to-back ALU retirement
    add("idle_after_reset", 1, 0, 0, 0, 1, 0, O,    1, 0, 0);
    for (int k = 0; k < 5; k++) add("alu_retire", 1, 0, 0, 0, 1, 0, IMPC, 0, 0, 0);
    add("alu_retire_cnt",   1, 0, 0, 0, 1, 0, IMPC, 1, 0, 5);
    add("rst_in_fetch",     0, 0, 0, 0, 0, 0, IM,   0, 0, 0);
    // Load with three dhit-less cycles; ihit ignored in DATA
    add("idle_ignores_req", 1, 1, 0, 0, 1, 0, O,    1, 0, 0);
    add("ld_accept",        1, 1, 0, 0, 1, 0, IM,   0, 0, 0);
    for (int k = 0; k < 3; k++) add("ld_wait", 1, 0, 0, 0, 1, 0, DR, 0, 0, 0);
    add("ld_hit",           1, 0, 0, 0, 0, 1, DRPC, 0, 0, 0);
    add("ld_back_fetch",    1, 0, 0, 0, 1, 0, IMPC, 1, 3, 1);
    // Store completing on first DATA cycle
    add("st_accept",        1, 0, 1, 0, 1, 0, IM,   1, 3, 2);
    add("st_hit",           1, 0, 0, 0, 0, 1, DWPC, 0, 0, 0);
    add("st_back_fetch",    1, 0, 0, 0, 0, 0, IM,   0, 0, 0);
    // HALT beats dREN_in, then holds against random hits
    add("halt_accept",      1, 1, 0, 1, 1, 0, IM,   0, 0, 0);
    for (int k = 0; k < 10; k++)
      add("halt_hold", 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), HL, 0, 0, 0);
    add("halt_hold_cnt",    1, 0, 0, 0, 1, 1, HL,   1, 4, 3);
    add("rst_in_halt",      0, 0, 0, 0, 0, 0, HL,   0, 0, 0);
    // Watchdog with WAIT_MAX=4
    add("wd_idle",          1, 0, 0, 0, 0, 0, O,    0, 0, 0);
    for (int k = 0; k < 4; k++) add("wd_wait_ok", 1, 0, 0, 0, 0, 0, IM, 0, 0, 0);
    for (int k = 0; k < 2; k++) add("wd_wait_err", 1, 0, 0, 0, 0, 0, IMER, 0, 0, 0);
    add("wd_retire",        1, 0, 0, 0, 1, 0, IMPCER, 0, 0, 0);
    add("wd_err_sticky",    1, 0, 0, 0, 0, 0, IMER, 1, 6, 1);
    add("rst_clears_err",   0, 0, 0, 0, 0, 0, IMER, 0, 0, 0);
    // Reset in DATA, then illegal read+write intent
    add("post_rst_idle",    1, 0, 0, 0, 0, 0, O,    1, 0, 0);
    add("st2_accept",       1, 0, 1, 0, 1, 0, IM,   0, 0, 0);
    add("st2_wait",         1, 0, 0, 0, 0, 0, DW,   0, 0, 0);
    add("rst_in_data",      0, 0, 0, 0, 0, 0, DW,   0, 0, 0);
    add("data_rst_idle",    1, 0, 0, 0, 0, 0, O,    1, 0, 0);
    add("ill_accept",       1, 1, 1, 0, 1, 0, IM,   0, 0, 0);
    add("ill_wait",         1, 0, 0, 0, 0, 0, DWER, 0, 0, 0);
    add("ill_hit",          1, 0, 0, 0, 0, 1, DWPCER, 0, 0, 0);
    add("ill_back_fetch",   1, 0, 0, 0, 0, 0, IMER, 1, 1, 1);

    nRST = 1'b0; dREN_in = 1'b0; dWEN_in = 1'b0; halt_in = 1'b0; ihit = 1'b0; dhit = 1'b0;
    repeat (2) @(posedge CLK);

    for (int r = 0; r < tbl.size(); r++) begin
      @(posedge CLK);
      #1;
      v = tbl[r];
      nRST = v.nrst; dREN_in = v.dren; dWEN_in = v.dwen; halt_in = v.halt;
      ihit = v.ih; dhit = v.dh;
      sb.push_back(v);
      @(negedge CLK);
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL scoreboard_empty row=%0d", r);
        continue;
      end
      e = sb.pop_front();
      act = {imemREN, dmemREN, dmemWEN, pc_en, halted, req_err};
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL %s row=%0d outputs{imem,dren,dwen,pc_en,halted,err} got=%b want=%b",
                 e.name, r, act, e.exp);
      end
      if (e.chk_cnt) begin
        exp_s = PERF ? CNT_W'(e.stall) : '0;
        exp_i = PERF ? CNT_W'(e.instr) : '0;
        checks++;
        if (stall_cnt !== exp_s) begin
          failures++;
          $display("FAIL %s_stall_cnt row=%0d got=%0d want=%0d", e.name, r, stall_cnt, exp_s);
        end
        checks++;
        if (instr_cnt !== exp_i) begin
          failures++;
          $display("FAIL %s_instr_cnt row=%0d got=%0d want=%0d", e.name, r, instr_cnt, exp_i);
        end
      end
    end

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_request_unit.md
Name: mem_request_unit

Overview:
- Sequential counterpart to the instruction decoder in the single-cycle MIPS datapath.
- Consumes the decoder's memory-intent outputs (dREN, dWEN, halt) and issues instruction/data requests to the memory controller.
- Waits on ihit/dhit and produces the PC enable that retires each instruction.
- Holds the datapath in a terminal halted state after HALT.

Parameters:
- CNT_W, 32, width of performance counters (only used when REQ_PERF_CNT_EN is defined)
- WAIT_MAX, 255, watchdog limit in cycles waiting for a hit; 0 disables the watchdog

Ports:
- CLK  input  1  system clock, rising edge
- nRST  input  1  synchronous active-low reset, sampled on rising edge of CLK
- dREN_in  input  1  decoder: current instruction loads from memory
- dWEN_in  input  1  decoder: current instruction stores to memory
- halt_in  input  1  decoder: current instruction is HALT
- ihit  input  1  memory: instruction word valid this cycle
- dhit  input  1  memory: data access completes this cycle
- imemREN  output  1  instruction fetch request
- dmemREN  output  1  data read request
- dmemWEN  output  1  data write request
- pc_en  output  1  one-cycle pulse; PC/register file commit this instruction
- halted  output  1  processor halted, sticky until reset
- req_err  output  1  sticky error flag: illegal dREN_in&dWEN_in, or watchdog expiry
- stall_cnt  output  CNT_W  cycles spent waiting on any hit
- instr_cnt  output  CNT_W  retired instructions

Behaviour:
- Clock and reset: single clock CLK; reset nRST is synchronous and active-low. Reset applies at a CLK edge with nRST=0.
- Reset state: state=IDLE, all flags cleared, wait counter=0, counters=0.
- Outputs in IDLE: imemREN=0, dmemREN=0, dmemWEN=0, pc_en=0, halted=0, req_err=0.
- Outputs are decoded from the registered state and registered flags only, with one exception: pc_en is combinational on hit inputs in FETCH and DATA.
- IDLE: all requests 0; unconditionally moves to FETCH next cycle. The first fetch request appears 1 cycle after reset is released.
- FETCH: imemREN=1, dmem*=0.
  - ihit=0: stay, wait counter +1.
  - ihit=1 and halt_in=1: go to HALT, pc_en=0.
  - ihit=1 and (dREN_in|dWEN_in): latch rd_q=dREN_in&~dWEN_in and wr_q=dWEN_in, go to DATA, pc_en=0.
  - ihit=1 otherwise: pc_en=1 this cycle, stay in FETCH. Back-to-back ALU instructions retire one per ihit cycle.
  - halt_in has priority over dREN_in/dWEN_in.
- DATA: imemREN=0, dmemREN=rd_q, dmemWEN=wr_q.
  - dhit=0: stay, wait counter +1.
  - dhit=1: pc_en=1 this cycle, clear rd_q/wr_q, go to FETCH.
  - ihit is ignored in DATA.
- HALT: all requests 0, pc_en=0, halted=1. Exit only by reset. All hit inputs are ignored.
- Illegal intent: dREN_in=1 and dWEN_in=1 at the accepting ihit. The write wins (wr_q=1, rd_q=0), and req_err is set the next cycle.
- Watchdog (WAIT_MAX>0):
  - The wait counter resets to 0 on every state change and on every pc_en.
  - When it reaches WAIT_MAX while still waiting, req_err is set and the FSM stays in its state (no forced exit).
  - The counter saturates at WAIT_MAX.
- req_err stays set until reset.
- Reset mid-operation: nRST=0 in DATA or FETCH drops every request the next cycle (state goes to IDLE). No pending data access survives reset.
- Latency: non-memory instruction retires 0 cycles after ihit. Memory instruction retires 0 cycles after dhit, which comes at least 1 cycle after ihit.

Optional Feature:
- Macro: REQ_PERF_CNT_EN.
- When defined:
  - stall_cnt increments each cycle in FETCH with ihit=0 or DATA with dhit=0.
  - instr_cnt increments on each pc_en.
  - Both saturate at all-ones and clear on reset.
- When undefined: both counter registers are absent; stall_cnt and instr_cnt are driven constant 0.

Test Plan:
- Reset release, ihit held 1, dREN_in=dWEN_in=halt_in=0:
  - cycle 0 after release: IDLE, imemREN=0.
  - cycle 1 onward: imemREN=1, pc_en=1 every cycle.
  - after 5 cycles of retiring: instr_cnt=5 (with REQ_PERF_CNT_EN).
- Load with ihit=1 and dREN_in=1, then dhit=0 for 3 cycles, then dhit=1:
  - next cycle: dmemREN=1, imemREN=0.
  - pc_en=1 only in the dhit cycle, then FETCH with imemREN=1.
  - stall_cnt=3.
- Store with dWEN_in=1 and dhit on the first DATA cycle: dmemWEN=1 for exactly 1 cycle, pc_en=1 in that cycle, dmemREN never asserted.
- ihit=1 with halt_in=1 and dREN_in=1 simultaneously: next cycle halted=1 and all requests 0, pc_en never pulses; halted persists through 10 cycles of random ihit/dhit until nRST=0.
- WAIT_MAX=4, FETCH with ihit=0 for 6 cycles: req_err=1 from the 5th wait cycle, imemREN remains 1. Then ihit=1: pc_en=1 and req_err stays 1.
- In DATA with dmemWEN=1, assert nRST=0 for 1 cycle: next cycle all outputs 0 (IDLE), then FETCH with imemREN=1. Also drive dREN_in=dWEN_in=1 at an ihit: dmemWEN=1, dmemREN=0, req_err=1.
